// File: rtl/serial_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, start/busy/done handshake.
// Define SERIAL_ADD_SUB_SAT_EN to saturate the signed result on overflow.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, res_r, res_nxt, sum_nxt;
    logic             carry_r;
    logic [CW-1:0]    idx_r;
    logic [CHUNK-1:0] a_ck, b_ck;
    logic [CHUNK:0]   csum;
    logic             accept, fin, c_msb, ovf_nxt;

`ifdef SERIAL_ADD_SUB_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic ovf_f,
                                                  input logic a_msb);
        logic [WIDTH-1:0] r;
        r = raw;
        if (ovf_f)
            r = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return r;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (idx_r == CW'(NCHUNK - 1)) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // One chunk slice of the ripple; carry into the MSB is recovered from the sum bit.
    always_comb begin
        a_ck    = a_r[idx_r*CHUNK +: CHUNK];
        b_ck    = b_r[idx_r*CHUNK +: CHUNK];
        csum    = {1'b0, a_ck} + {1'b0, b_ck} + {{CHUNK{1'b0}}, carry_r};
        res_nxt = res_r;
        res_nxt[idx_r*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        c_msb   = csum[CHUNK-1] ^ a_ck[CHUNK-1] ^ b_ck[CHUNK-1];
        ovf_nxt = c_msb ^ csum[CHUNK];
`ifdef SERIAL_ADD_SUB_SAT_EN
        sum_nxt = saturate(res_nxt, ovf_nxt, a_r[WIDTH-1]);
`else
        sum_nxt = res_nxt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            done <= fin;
            if (accept) begin
                // Subtraction is A + ~B + ~borrow.
                a_r     <= a;
                b_r     <= b ^ {WIDTH{mode}};
                carry_r <= cin ^ mode;
                idx_r   <= '0;
            end else if (state == RUN) begin
                res_r   <= res_nxt;
                carry_r <= csum[CHUNK];
                idx_r   <= idx_r + CW'(1);
            end
            if (fin) begin
                sum  <= sum_nxt;
                cout <= csum[CHUNK];
                ovf  <= ovf_nxt;
                zero <= (sum_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at WIDTH=16, CHUNK=4.
module tb_serial_add_sub;

    logic        clk, rst_n, start, mode, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf, zero;
    logic [15:0] sum;

    int n_checks = 0;
    int n_errors = 0;
    int lat, bcnt, extra;

    serial_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1ns after an edge; returns 1ns after the accepting edge.
    task automatic launch(input logic [15:0] ia, input logic [15:0] ib,
                          input logic im, input logic ic);
        start = 1'b1; a = ia; b = ib; mode = im; cin = ic;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int l, output int bc);
        l  = 0;
        bc = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) bc++;
            @(posedge clk); #1;
            if (done) begin
                l = k;
                break;
            end
        end
        if (l == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf, zero}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: plain add, latency and busy length
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        chk("t1_busy_after_start", busy, 1);
        wait_done(lat, bcnt);
        chk("t1_latency", lat, 4);
        chk("t1_busy_cycles", bcnt, 4);
        chk("t1_sum", sum, 16'h5555);
        chk("t1_cout_ovf_zero", {cout, ovf, zero}, 3'b000);
        chk("t1_busy_at_done", busy, 0);
        @(posedge clk); #1;
        chk("t1_done_pulse", done, 0);
        chk("t1_sum_hold", sum, 16'h5555);

        // 2: subtraction with and without borrow-in
        launch(16'h0005, 16'h000A, 1'b1, 1'b0);
        wait_done(lat, bcnt);
        chk("t2a_sum", sum, 16'hFFFB);
        chk("t2a_cout_ovf", {cout, ovf}, 2'b00);
        launch(16'h000A, 16'h0003, 1'b1, 1'b1);
        wait_done(lat, bcnt);
        chk("t2b_sum", sum, 16'h0006);
        chk("t2b_cout_ovf_zero", {cout, ovf, zero}, 3'b100);

        // 3: carry out and zero
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(lat, bcnt);
        chk("t3_sum", sum, 16'h0000);
        chk("t3_cout_ovf_zero", {cout, ovf, zero}, 3'b101);

        // 4: positive and negative overflow
        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(lat, bcnt);
`ifdef SERIAL_ADD_SUB_SAT_EN
        chk("t4a_sum", sum, 16'h7FFF);
`else
        chk("t4a_sum", sum, 16'h8000);
`endif
        chk("t4a_cout_ovf_zero", {cout, ovf, zero}, 3'b010);
        launch(16'h8000, 16'h0001, 1'b1, 1'b0);
        wait_done(lat, bcnt);
`ifdef SERIAL_ADD_SUB_SAT_EN
        chk("t4b_sum", sum, 16'h8000);
`else
        chk("t4b_sum", sum, 16'h7FFF);
`endif
        chk("t4b_cout_ovf_zero", {cout, ovf, zero}, 3'b110);

        // 5a: start pulsed while busy is ignored
        launch(16'h0100, 16'h0023, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; a = 16'hAAAA; b = 16'h1111; mode = 1'b1; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("t5a_latency", lat, 2);
        chk("t5a_sum", sum, 16'h0123);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("t5a_extra_done", extra, 0);
        chk("t5a_idle", busy, 0);

        // 5b: start accepted in the done cycle
        launch(16'h0011, 16'h0022, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        chk("t5b_first_sum", sum, 16'h0034);
        launch(16'h1000, 16'h0001, 1'b1, 1'b0);
        chk("t5b_busy", busy, 1);
        chk("t5b_done_low", done, 0);
        wait_done(lat, bcnt);
        chk("t5b_latency", lat, 4);
        chk("t5b_sum", sum, 16'h0FFF);

        // 6: reset mid-operation
        launch(16'h2222, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_sum", sum, 16'h0000);
        chk("t6_flags", {cout, ovf, zero}, 3'b000);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("t6_no_done", extra, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        launch(16'h0003, 16'h0004, 1'b0, 1'b0);
        wait_done(lat, bcnt);
        chk("t6_after_sum", sum, 16'h0007);
        chk("t6_after_latency", lat, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
